// File: rtl/alu_exec_seq_if.sv
// ---------------------------------------------------------------------------
// alu_exec_seq_if
//   Bundles the instruction handshake and the ALU-side bus of the execute-stage
//   sequencer.
//
//   Signals:
//     instr_i          16      instruction word
//     imm_i            DATA_W  immediate operand, sampled with instr_i
//     instr_valid_i    1       instruction offered
//     instr_ready_o    1       sequencer can accept an instruction
//     alu_opcode_o     3       to ALU opcode_i
//     alu_operand_a_o  DATA_W  to ALU operand_a_i
//     alu_operand_b_o  DATA_W  to ALU operand_b_i
//     alu_en_o         1       to ALU alu_en_i
//     alu_result_i     DATA_W  from ALU result_o
//
//   Modports:
//     master : the sequencer (drives ready and the ALU inputs)
//     slave  : instruction source plus ALU (drives instruction and result)
// ---------------------------------------------------------------------------
interface alu_exec_seq_if #(
    parameter int DATA_W = 8
);
    logic [15:0]       instr_i;
    logic [DATA_W-1:0] imm_i;
    logic              instr_valid_i;
    logic              instr_ready_o;
    logic [2:0]        alu_opcode_o;
    logic [DATA_W-1:0] alu_operand_a_o;
    logic [DATA_W-1:0] alu_operand_b_o;
    logic              alu_en_o;
    logic [DATA_W-1:0] alu_result_i;

    modport master (
        input  instr_i,
        input  imm_i,
        input  instr_valid_i,
        output instr_ready_o,
        output alu_opcode_o,
        output alu_operand_a_o,
        output alu_operand_b_o,
        output alu_en_o,
        input  alu_result_i
    );

    modport slave (
        output instr_i,
        output imm_i,
        output instr_valid_i,
        input  instr_ready_o,
        input  alu_opcode_o,
        input  alu_operand_a_o,
        input  alu_operand_b_o,
        input  alu_en_o,
        output alu_result_i
    );
endinterface

// File: rtl/alu_exec_seq.sv
// ---------------------------------------------------------------------------
// alu_exec_seq
//   Execute-stage sequencer in front of the 8-bit ALU. Accepts one instruction
//   at a time, reads operands from a 4-entry register file, drives the ALU,
//   captures its result and writes it back. Also handles load-immediate and NOP.
//
//   Instruction word: [15:14] kind, [13:11] op, [10:9] rd, [8:7] ra, [6:5] rb,
//   [4:0] ignored. kind: 00 rd=ra op rb, 01 rd=ra op imm, 10 rd=imm, 11 NOP.
//
//   Ports:
//     clk_i       in   system clock, rising edge
//     rst_i       in   asynchronous active-high reset
//     bus         if   alu_exec_seq_if.master (handshake + ALU bus)
//     done_o      out  one-cycle pulse when an instruction retires
//     dbg_sel_i   in   register-file debug read select
//     dbg_data_o  out  combinational read of regfile[dbg_sel_i]
//     zero_o      out  (ALU_FLAGS_EN only) last ALU result was zero
//     neg_o       out  (ALU_FLAGS_EN only) MSB of last ALU result
//
//   Optional build macro: ALU_FLAGS_EN adds the registered zero_o/neg_o flags.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | ready for an instruction; NOP retires here directly
//   READ  | register operands/opcode toward the ALU, raise alu_en
//   EXEC  | ALU result stable; capture it, drop alu_en
//   WRITE | done_o high; regfile[rd] written on the exiting edge
// ---------------------------------------------------------------------------
module alu_exec_seq #(
    parameter int                DATA_W   = 8,
    parameter logic [DATA_W-1:0] REG_INIT = 8'h00
) (
    input  logic                clk_i,
    input  logic                rst_i,
    alu_exec_seq_if.master      bus,
    output logic                done_o,
    input  logic [1:0]          dbg_sel_i,
`ifdef ALU_FLAGS_EN
    output logic                zero_o,
    output logic                neg_o,
`endif
    output logic [DATA_W-1:0]   dbg_data_o
);

    localparam logic [1:0] K_RR  = 2'b00;
    localparam logic [1:0] K_RI  = 2'b01;
    localparam logic [1:0] K_LDI = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_EXEC  = 2'd2,
        S_WRITE = 2'd3
    } state_t;

    state_t            r_state;
    logic              r_ready;
    logic              r_done;
    logic              r_alu_en;
    logic [2:0]        r_opcode;
    logic [DATA_W-1:0] r_op_a;
    logic [DATA_W-1:0] r_op_b;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_imm;
    logic [1:0]        r_kind;
    logic [2:0]        r_op;
    logic [1:0]        r_rd;
    logic [1:0]        r_ra;
    logic [1:0]        r_rb;
    logic [DATA_W-1:0] r_regs [4];
`ifdef ALU_FLAGS_EN
    logic              r_zero;
    logic              r_neg;
`endif

    // Reserved instruction bits are intentionally ignored.
    logic w_unused;
    assign w_unused = &{1'b0, bus.instr_i[4:0]};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state  <= S_IDLE;
            r_ready  <= 1'b1;
            r_done   <= 1'b0;
            r_alu_en <= 1'b0;
            r_opcode <= '0;
            r_op_a   <= '0;
            r_op_b   <= '0;
            r_wdata  <= '0;
            r_imm    <= '0;
            r_kind   <= '0;
            r_op     <= '0;
            r_rd     <= '0;
            r_ra     <= '0;
            r_rb     <= '0;
            for (int i = 0; i < 4; i++) begin
                r_regs[i] <= REG_INIT;
            end
`ifdef ALU_FLAGS_EN
            r_zero   <= 1'b0;
            r_neg    <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.instr_valid_i) begin
                        // Latch the whole instruction now; later input changes are don't-care.
                        r_kind <= bus.instr_i[15:14];
                        r_op   <= bus.instr_i[13:11];
                        r_rd   <= bus.instr_i[10:9];
                        r_ra   <= bus.instr_i[8:7];
                        r_rb   <= bus.instr_i[6:5];
                        r_imm  <= bus.imm_i;
                        case (bus.instr_i[15:14])
                            K_RR, K_RI: begin
                                r_state <= S_READ;
                                r_ready <= 1'b0;
                            end
                            K_LDI: begin
                                r_wdata <= bus.imm_i;
                                r_done  <= 1'b1;
                                r_state <= S_WRITE;
                                r_ready <= 1'b0;
                            end
                            default: begin
                                // NOP retires without leaving IDLE.
                                r_done <= 1'b1;
                            end
                        endcase
                    end
                end
                S_READ: begin
                    r_op_a   <= r_regs[r_ra];
                    r_op_b   <= (r_kind == K_RR) ? r_regs[r_rb] : r_imm;
                    r_opcode <= r_op;
                    r_alu_en <= 1'b1;
                    r_state  <= S_EXEC;
                end
                S_EXEC: begin
                    // Operands and opcode are left untouched so the ALU's held output stays coherent.
                    r_wdata  <= bus.alu_result_i;
                    r_alu_en <= 1'b0;
                    r_done   <= 1'b1;
                    r_state  <= S_WRITE;
                end
                S_WRITE: begin
                    r_regs[r_rd] <= r_wdata;
`ifdef ALU_FLAGS_EN
                    if (r_kind != K_LDI) begin
                        r_zero <= (r_wdata == '0);
                        r_neg  <= r_wdata[DATA_W-1];
                    end
`endif
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.instr_ready_o   = r_ready;
    assign bus.alu_opcode_o    = r_opcode;
    assign bus.alu_operand_a_o = r_op_a;
    assign bus.alu_operand_b_o = r_op_b;
    assign bus.alu_en_o        = r_alu_en;
    assign done_o              = r_done;
    assign dbg_data_o          = r_regs[dbg_sel_i];
`ifdef ALU_FLAGS_EN
    assign zero_o              = r_zero;
    assign neg_o               = r_neg;
`endif

endmodule

// File: tb/tb_alu_exec_seq.sv
module tb_alu_exec_seq;

    localparam logic [1:0] K_RR  = 2'b00;
    localparam logic [1:0] K_RI  = 2'b01;
    localparam logic [1:0] K_LDI = 2'b10;
    localparam logic [1:0] K_NOP = 2'b11;

    logic       clk;
    logic       rst;
    logic       done;
    logic [1:0] dbg_sel;
    logic [7:0] dbg_data;
`ifdef ALU_FLAGS_EN
    logic       zero;
    logic       neg;
    logic       m_zero;
    logic       m_neg;
`endif

    alu_exec_seq_if #(.DATA_W(8)) bus ();

    alu_exec_seq #(.DATA_W(8), .REG_INIT(8'h00)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .bus        (bus),
        .done_o     (done),
        .dbg_sel_i  (dbg_sel),
`ifdef ALU_FLAGS_EN
        .zero_o     (zero),
        .neg_o      (neg),
`endif
        .dbg_data_o (dbg_data)
    );

    // Reference ALU: combinational, output garbage while not enabled so that a
    // capture outside EXEC is visible.
    function automatic logic [7:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'b100:  return a ^ b;
            3'b101:  return ~(a ^ b);
            3'b110:  return a + b;
            3'b111:  return a - b;
            default: return a & b;
        endcase
    endfunction

    assign bus.alu_result_i = bus.alu_en_o ? alu_f(bus.alu_opcode_o, bus.alu_operand_a_o, bus.alu_operand_b_o) : 8'hA5;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] rd;
        logic [7:0] val;
    } sb_t;

    sb_t        sb_q [$];
    logic [7:0] m [4];
    int         n_checks;
    int         n_errors;
    bit         pend;
    logic [7:0] pend_val;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge and service the write-back scoreboard.
    task automatic tick();
        sb_t e;
        @(negedge clk);
        if (pend) begin
            chk("sb_writeback", {8'h00, dbg_data}, {8'h00, pend_val});
            pend = 1'b0;
        end
        if (done === 1'b1) begin
            chk("sb_expected_entry", {15'd0, sb_q.size() != 0}, 16'd1);
            if (sb_q.size() != 0) begin
                e        = sb_q.pop_front();
                dbg_sel  = e.rd;
                pend_val = e.val;
                pend     = 1'b1;
            end
        end
    endtask

    task automatic issue(input logic [1:0] kind, input logic [2:0] op, input logic [1:0] rd,
                         input logic [1:0] ra, input logic [1:0] rb, input logic [7:0] imm,
                         input logic [7:0] exp, input bit hold);
        int         lat;
        int         n;
        sb_t        e;
        logic [7:0] exp_a;
        logic [7:0] exp_b;
        lat   = (kind == K_NOP || kind == K_LDI) ? 1 : 3;
        exp_a = m[ra];
        exp_b = (kind == K_RR) ? m[rb] : imm;
        bus.instr_i       = {kind, op, rd, ra, rb, 5'b10101};
        bus.imm_i         = imm;
        bus.instr_valid_i = 1'b1;
        n = 0;
        while (bus.instr_ready_o !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("accept_timeout", {15'd0, n < 20}, 16'd1);
        e.rd  = rd;
        e.val = (kind == K_NOP) ? m[rd] : exp;
        sb_q.push_back(e);
        if (kind != K_NOP) m[rd] = exp;
        tick();
        if (!hold) begin
            bus.instr_valid_i = 1'b0;
            bus.instr_i       = ~bus.instr_i;
            bus.imm_i         = ~bus.imm_i;
        end
        for (int c = 1; c <= lat; c++) begin
            if (c > 1) tick();
            chk("alu_en_window", {15'd0, bus.alu_en_o}, {15'd0, (lat == 3 && c == 2)});
            chk("done_timing", {15'd0, done}, {15'd0, c == lat});
            chk("ready_busy", {15'd0, bus.instr_ready_o}, {15'd0, kind == K_NOP});
            if (lat == 3 && c == 2) begin
                chk("opcode", {13'd0, bus.alu_opcode_o}, {13'd0, op});
                chk("operand_a", {8'h00, bus.alu_operand_a_o}, {8'h00, exp_a});
                chk("operand_b", {8'h00, bus.alu_operand_b_o}, {8'h00, exp_b});
            end
        end
        tick();
        chk("ready_back", {15'd0, bus.instr_ready_o}, 16'd1);
        chk("done_single", {15'd0, done}, 16'd0);
`ifdef ALU_FLAGS_EN
        if (kind == K_RR || kind == K_RI) begin
            m_zero = (exp == 8'h00);
            m_neg  = exp[7];
        end
        chk("zero_flag", {15'd0, zero}, {15'd0, m_zero});
        chk("neg_flag", {15'd0, neg}, {15'd0, m_neg});
`endif
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        pend     = 1'b0;
        pend_val = 8'h00;
        for (int i = 0; i < 4; i++) m[i] = 8'h00;
`ifdef ALU_FLAGS_EN
        m_zero = 1'b0;
        m_neg  = 1'b0;
`endif
        rst               = 1'b1;
        dbg_sel           = 2'd0;
        bus.instr_i       = 16'h0000;
        bus.imm_i         = 8'h00;
        bus.instr_valid_i = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("rst_ready", {15'd0, bus.instr_ready_o}, 16'd1);
        chk("rst_alu_en", {15'd0, bus.alu_en_o}, 16'd0);
        chk("rst_done", {15'd0, done}, 16'd0);
        chk("rst_opcode", {13'd0, bus.alu_opcode_o}, 16'd0);
        chk("rst_operand_a", {8'h00, bus.alu_operand_a_o}, 16'd0);
        chk("rst_operand_b", {8'h00, bus.alu_operand_b_o}, 16'd0);
`ifdef ALU_FLAGS_EN
        chk("rst_zero", {15'd0, zero}, 16'd0);
        chk("rst_neg", {15'd0, neg}, 16'd0);
`endif

        // Register reset value observed through a NOP retirement.
        issue(K_NOP, 3'b000, 2'd1, 2'd0, 2'd0, 8'hEE, 8'h00, 1'b0);

        issue(K_LDI, 3'b000, 2'd1, 2'd0, 2'd0, 8'h3C, 8'h3C, 1'b0);
        issue(K_LDI, 3'b000, 2'd2, 2'd0, 2'd0, 8'h0F, 8'h0F, 1'b0);
        issue(K_RR,  3'b110, 2'd3, 2'd1, 2'd2, 8'h00, 8'h4B, 1'b0);

        issue(K_LDI, 3'b000, 2'd1, 2'd0, 2'd0, 8'h0F, 8'h0F, 1'b0);
        issue(K_RI,  3'b111, 2'd0, 2'd1, 2'd0, 8'h10, 8'hFF, 1'b0);

        issue(K_LDI, 3'b000, 2'd1, 2'd0, 2'd0, 8'h5A, 8'h5A, 1'b0);
        issue(K_RR,  3'b101, 2'd1, 2'd1, 2'd1, 8'h00, 8'hFF, 1'b0);
        issue(K_RR,  3'b100, 2'd1, 2'd1, 2'd1, 8'h00, 8'h00, 1'b0);

        // Valid held high across four instructions; each is taken once.
        issue(K_LDI, 3'b000, 2'd2, 2'd0, 2'd0, 8'h81, 8'h81, 1'b1);
        issue(K_RR,  3'b110, 2'd2, 2'd2, 2'd0, 8'h00, 8'h80, 1'b1);
        issue(K_LDI, 3'b000, 2'd3, 2'd0, 2'd0, 8'h77, 8'h77, 1'b1);
        issue(K_NOP, 3'b110, 2'd2, 2'd2, 2'd2, 8'h00, 8'h00, 1'b0);

        // Reset asserted during EXEC of an ADD into r3.
        bus.instr_i       = {K_RR, 3'b110, 2'd3, 2'd2, 2'd2, 5'd0};
        bus.imm_i         = 8'h00;
        bus.instr_valid_i = 1'b1;
        chk("mid_rst_ready", {15'd0, bus.instr_ready_o}, 16'd1);
        tick();
        bus.instr_valid_i = 1'b0;
        tick();
        chk("mid_rst_exec_en", {15'd0, bus.alu_en_o}, 16'd1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_alu_en_async", {15'd0, bus.alu_en_o}, 16'd0);
        chk("mid_rst_done", {15'd0, done}, 16'd0);
        chk("mid_rst_ready_async", {15'd0, bus.instr_ready_o}, 16'd1);
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) m[i] = 8'h00;
        tick();
        chk("post_rst_ready", {15'd0, bus.instr_ready_o}, 16'd1);
        chk("post_rst_done", {15'd0, done}, 16'd0);
`ifdef ALU_FLAGS_EN
        m_zero = 1'b0;
        m_neg  = 1'b0;
        chk("post_rst_zero", {15'd0, zero}, 16'd0);
        chk("post_rst_neg", {15'd0, neg}, 16'd0);
`endif
        issue(K_NOP, 3'b000, 2'd3, 2'd0, 2'd0, 8'h00, 8'h00, 1'b0);
        issue(K_NOP, 3'b000, 2'd2, 2'd0, 2'd0, 8'h00, 8'h00, 1'b0);
        tick();
        chk("sb_drained", {15'd0, sb_q.size() == 0}, 16'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_exec_seq.md
Name: alu_exec_seq

Overview:
- Execute-stage sequencer sitting directly upstream of the 8-bit ALU.
- Accepts one instruction at a time over a valid/ready handshake and reads operands from an internal 4x8 register file.
- Drives the ALU opcode, operand and enable inputs, captures the ALU result, and writes it back to the register file.
- Also supports load-immediate and NOP, so the ALU can be exercised end-to-end from a simple instruction stream.

Parameters:
- DATA_W, 8, datapath width; must match the ALU (8).
- REG_INIT, 8'h00, reset value of every register-file entry.

Ports:
- clk_i  input  1  system clock, all state on rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- instr_i  input  16  instruction word, format below.
- imm_i  input  DATA_W  immediate operand, sampled with instr_i.
- instr_valid_i  input  1  instruction offered.
- instr_ready_o  output  1  sequencer can accept an instruction.
- alu_opcode_o  output  3  to ALU opcode_i.
- alu_operand_a_o  output  DATA_W  to ALU operand_a_i.
- alu_operand_b_o  output  DATA_W  to ALU operand_b_i.
- alu_en_o  output  1  to ALU alu_en_i.
- alu_result_i  input  DATA_W  from ALU result_o.
- done_o  output  1  one-cycle pulse when an instruction retires.
- dbg_sel_i  input  2  register select for debug read.
- dbg_data_o  output  DATA_W  combinational read of regfile[dbg_sel_i].

Behaviour:
- Instruction fields: [15:14] kind, [13:11] op, [10:9] rd, [8:7] ra, [6:5] rb, [4:0] reserved (ignored).
- kind encodings:
  - 00 ALU reg-reg: rd = ra op rb.
  - 01 ALU reg-imm: rd = ra op imm.
  - 10 LDI: rd = imm.
  - 11 NOP.
- States: IDLE, READ, EXEC, WRITE. instr_ready_o = (state==IDLE).
- Handshake: transfer occurs on a rising edge with instr_valid_i & instr_ready_o. instr_i and imm_i are latched then, and later changes have no effect.
- IDLE, transfer:
  - NOP: go to IDLE and pulse done_o next cycle; no register change.
  - LDI: go to WRITE.
  - Otherwise: go to READ.
- READ (1 cycle): register alu_operand_a_o <= reg[ra]; alu_operand_b_o <= reg[rb] (kind 00) or imm (kind 01); alu_opcode_o <= op; alu_en_o <= 1. Go to EXEC.
- EXEC (1 cycle): ALU outputs are stable with alu_en_o=1. Capture alu_result_i into a write-data register, clear alu_en_o, go to WRITE.
  - Operand and opcode outputs hold their values after EXEC until the next READ, so the ALU's held output stays consistent.
- WRITE (1 cycle): done_o=1; reg[rd] <= write data (result or imm) on the exiting edge. Go to IDLE.
- Latency from the transfer edge T:
  - ALU ops: READ at T+1, EXEC at T+2, WRITE at T+3, regfile updated at edge T+4, ready again at T+4. Throughput one ALU op per 4 cycles.
  - LDI: WRITE at T+1, 2-cycle occupancy.
- Hazards:
  - rd equal to ra or rb is legal. Operands are read in READ, before the write.
  - Back-to-back dependent instructions see the updated value because the write completes before the next READ.
- Arithmetic: modulo 2^DATA_W; no carry is kept. Subtract (op 111) is wrap-around.
- dbg_data_o reflects the write on the cycle after the WRITE edge.
- Reset values:
  - state IDLE, so instr_ready_o=1 once reset is released.
  - alu_en_o, done_o, alu_opcode_o, both operands and the write-data register are all 0.
  - All registers = REG_INIT.
- Reset mid-operation: the in-flight instruction is abandoned with no register write and no done_o. alu_en_o drops immediately (asynchronously).
- instr_valid_i while not ready: ignored, not queued. The source must hold the instruction until it is accepted.

Optional Feature:
- Macro ALU_FLAGS_EN.
- When defined:
  - Adds outputs zero_o (1 bit) and neg_o (1 bit), both registered and reset to 0.
  - Updated on the WRITE edge of ALU ops only: zero_o = (result==0), neg_o = result[DATA_W-1].
  - LDI and NOP leave the flags unchanged.
- When undefined: the ports and flag logic are absent, and all other behaviour is identical.

Test Plan:
- Reset, then LDI r1=8'h3C, LDI r2=8'h0F -> done_o pulses once per instruction; dbg_sel=1 reads 3C, dbg_sel=2 reads 0F; instr_ready_o low for exactly 1 cycle per LDI.
- r1=3C, r2=0F; ALU op 110 rd=3 ra=1 rb=2 -> alu_en_o high exactly in EXEC (T+2); r3=8'h4B at T+4; ready reasserted at T+4.
- r1=0F; op 111 reg-imm rd=0 ra=1 imm=8'h10 -> r0=8'hFF. With ALU_FLAGS_EN: neg_o=1, zero_o=0.
- op 101 (XNOR) rd=1 ra=1 rb=1 with r1=5A -> r1=FF. Then op 100 (XOR) same regs -> r1=00; with flags, zero_o=1.
- instr_valid_i held high with 4 queued instructions -> exactly one accepted per ready window; NOP retires with a done_o pulse and no register change.
- Assert rst_i during EXEC of an ADD into r3 (r3=77 beforehand) -> r3 becomes REG_INIT, no done_o, alu_en_o=0 immediately, instr_ready_o=1 after release.
